// File: rtl/alu_mdu_pkg.sv
// alu_mdu_pkg: shared definitions for the sequential ALU / multiply-divide unit.
//   - opcode constants (MIPS funct field encoding)
//   - FSM state type used by the top-level controller
package alu_mdu_pkg;

  localparam logic [5:0] OP_AND   = 6'b100100;
  localparam logic [5:0] OP_OR    = 6'b100101;
  localparam logic [5:0] OP_ADD   = 6'b100000;
  localparam logic [5:0] OP_SUB   = 6'b100010;
  localparam logic [5:0] OP_SLT   = 6'b101010;
  localparam logic [5:0] OP_SRL   = 6'b000010;
  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_e;

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: iterative unsigned multiply (shift-add) / divide (restoring) datapath.
// One step per cycle while i_run is high; WIDTH steps per operation.
// Ports:
//   clk, i_rst_n      clock, async active-low reset
//   i_load            capture operands and mode, clear accumulator/counter
//   i_mode            0 = multiply (a*b), 1 = divide (a/b)
//   i_run             perform one iteration this cycle
//   i_a, i_b          operands (a = multiplicand / dividend, b = multiplier / divisor)
//   o_hi, o_lo        value of the accumulator after the step taken this cycle
//   o_last            this cycle's step is the final one; o_hi/o_lo hold the result
module mdu_iter
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_mode,
  input  logic             i_run,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_last
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST_CNT = SHW'(WIDTH - 1);

  logic             r_mode;
  logic [WIDTH-1:0] r_op;    // multiplicand or divisor
  logic [WIDTH-1:0] r_hi;    // product upper half / partial remainder
  logic [WIDTH-1:0] r_lo;    // multiplier bits / dividend bits -> quotient bits
  logic [SHW-1:0]   r_cnt;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_tmp;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_nxt_hi;
  logic [WIDTH-1:0] w_nxt_lo;
  logic             w_last;

  assign w_last = i_run & (r_cnt == LAST_CNT);

  // One multiply or divide step, computed from the current accumulator
  always_comb begin
    w_sum    = {1'b0, r_hi} + {1'b0, r_op};
    w_tmp    = {r_hi, r_lo[WIDTH-1]};
    w_diff   = w_tmp - {1'b0, r_op};
    w_nxt_hi = r_hi;
    w_nxt_lo = r_lo;
    if (r_mode) begin
      // Restoring divide; with a zero divisor every compare succeeds, so the
      // quotient fills with ones and the dividend shifts through into hi.
      if (w_tmp >= {1'b0, r_op}) begin
        w_nxt_hi = w_diff[WIDTH-1:0];
        w_nxt_lo = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_nxt_hi = w_tmp[WIDTH-1:0];
        w_nxt_lo = {r_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Shift-add: optionally add into the upper half, then shift {carry,hi,lo} right
      if (r_lo[0]) begin
        w_nxt_hi = w_sum[WIDTH:1];
        w_nxt_lo = {w_sum[0], r_lo[WIDTH-1:1]};
      end else begin
        w_nxt_hi = {1'b0, r_hi[WIDTH-1:1]};
        w_nxt_lo = {r_hi[0], r_lo[WIDTH-1:1]};
      end
    end
  end

  // Operand capture, iteration and counter
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode <= 1'b0;
      r_op   <= {WIDTH{1'b0}};
      r_hi   <= {WIDTH{1'b0}};
      r_lo   <= {WIDTH{1'b0}};
      r_cnt  <= {SHW{1'b0}};
    end else if (i_load) begin
      r_mode <= i_mode;
      r_hi   <= {WIDTH{1'b0}};
      r_cnt  <= {SHW{1'b0}};
      if (i_mode) begin
        r_op <= i_b;
        r_lo <= i_a;
      end else begin
        r_op <= i_a;
        r_lo <= i_b;
      end
    end else if (i_run) begin
      r_hi  <= w_nxt_hi;
      r_lo  <= w_nxt_lo;
      r_cnt <= w_last ? {SHW{1'b0}} : r_cnt + SHW'(1);
    end
  end

  assign o_hi   = w_nxt_hi;
  assign o_lo   = w_nxt_lo;
  assign o_last = w_last;

endmodule

// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: sequential ALU with registered result, start/busy/done handshake
// and an iterative MULTU/DIVU unit writing HI/LO.
// Ports:
//   clk, reset        clock, async active-low reset
//   start             launch an operation (ignored while busy)
//   dataA, dataB      operands
//   Signal            opcode (MIPS funct)
//   dataOut           registered result
//   hi, lo            HI/LO registers (written only by MULTU/DIVU)
//   busy              multiply/divide in progress
//   done              one-cycle pulse when dataOut is valid
module alu_mdu_seq
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] dataOut,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int SHW = $clog2(WIDTH);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_out_nxt;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_load;
  logic             w_mode;
  logic             w_run;
  logic [WIDTH-1:0] w_mdu_hi;
  logic [WIDTH-1:0] w_mdu_lo;
  logic             w_mdu_last;

  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk     (clk),
    .i_rst_n (reset),
    .i_load  (w_load),
    .i_mode  (w_mode),
    .i_run   (w_run),
    .i_a     (dataA),
    .i_b     (dataB),
    .o_hi    (w_mdu_hi),
    .o_lo    (w_mdu_lo),
    .o_last  (w_mdu_last)
  );

  // Single-cycle result mux; unknown opcodes yield zero
  always_comb begin
    w_alu = {WIDTH{1'b0}};
    case (Signal)
      OP_AND:  w_alu = dataA & dataB;
      OP_OR:   w_alu = dataA | dataB;
      OP_ADD:  w_alu = dataA + dataB;
      OP_SUB:  w_alu = dataA - dataB;
      OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
      OP_SRL:  w_alu = dataB >> dataA[SHW-1:0];
      OP_MFHI: w_alu = r_hi;
      OP_MFLO: w_alu = r_lo;
      default: w_alu = {WIDTH{1'b0}};
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_data_out;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_mode      = 1'b0;
    w_run       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (Signal == OP_MULTU) begin
            w_load      = 1'b1;
            w_mode      = 1'b0;
            w_busy_nxt  = 1'b1;
            w_state_nxt = MUL;
          end else if (Signal == OP_DIVU) begin
            w_load      = 1'b1;
            w_mode      = 1'b1;
            w_busy_nxt  = 1'b1;
            w_state_nxt = DIV;
          end else begin
            w_out_nxt   = w_alu;
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      MUL, DIV: begin
        w_run = 1'b1;
        if (w_mdu_last) begin
          w_hi_nxt    = w_mdu_hi;
          w_lo_nxt    = w_mdu_lo;
          w_out_nxt   = w_mdu_lo;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data_out <= {WIDTH{1'b0}};
      r_hi       <= {WIDTH{1'b0}};
      r_lo       <= {WIDTH{1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_data_out <= w_out_nxt;
      r_hi       <= w_hi_nxt;
      r_lo       <= w_lo_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign dataOut = r_data_out;
  assign hi      = r_hi;
  assign lo      = r_lo;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// tb_alu_mdu_seq: self-checking bench for alu_mdu_seq (WIDTH=32).
// Directed scenarios plus randomized operations compared against an
// arithmetic reference model of the result and HI/LO state.
module tb_alu_mdu_seq;
  import alu_mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [5:0]  Signal;
  logic [31:0] dataOut;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int n_chk;
  int n_pass;

  // reference model state
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  alu_mdu_seq #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .dataA   (dataA),
    .dataB   (dataB),
    .Signal  (Signal),
    .dataOut (dataOut),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SRL:  return b >> a[4:0];
      OP_MFHI: return m_hi;
      OP_MFLO: return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  // Issue one operation and check its full result/handshake behaviour
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] eh;
    logic [31:0] el;
    int          bc;
    int          guard;
    bit          dbusy;
    @(negedge clk);
    dataA  = a;
    dataB  = b;
    Signal = op;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (op == OP_MULTU || op == OP_DIVU) begin
      if (op == OP_MULTU) begin
        p  = {32'd0, a} * {32'd0, b};
        eh = p[63:32];
        el = p[31:0];
      end else if (b == 32'd0) begin
        el = 32'hFFFF_FFFF;
        eh = a;
      end else begin
        el = a / b;
        eh = a % b;
      end
      bc    = 0;
      guard = 0;
      dbusy = 1'b0;
      while (busy === 1'b1 && guard < 200) begin
        bc++;
        guard++;
        if (done !== 1'b0) dbusy = 1'b1;
        dataA = $urandom;
        dataB = $urandom;
        @(negedge clk);
      end
      chk_val($sformatf("busy_cycles op=%b", op), 64'(bc), 64'd32);
      chk_val("done_in_busy", {63'd0, dbusy}, 64'd0);
      chk_val("mdu_done", {63'd0, done}, 64'd1);
      chk_val($sformatf("mdu_dataOut %h,%h", a, b), {32'd0, dataOut}, {32'd0, el});
      chk_val($sformatf("mdu_hi %h,%h", a, b), {32'd0, hi}, {32'd0, eh});
      chk_val($sformatf("mdu_lo %h,%h", a, b), {32'd0, lo}, {32'd0, el});
      m_hi = eh;
      m_lo = el;
      @(negedge clk);
      chk_val("mdu_done_pulse", {63'd0, done}, 64'd0);
    end else begin
      el = alu_ref(op, a, b);
      chk_val($sformatf("alu_done op=%b", op), {63'd0, done}, 64'd1);
      chk_val("alu_busy", {63'd0, busy}, 64'd0);
      chk_val($sformatf("alu_dataOut op=%b %h,%h", op, a, b), {32'd0, dataOut}, {32'd0, el});
      chk_val("hi_hold", {32'd0, hi}, {32'd0, m_hi});
      chk_val("lo_hold", {32'd0, lo}, {32'd0, m_lo});
    end
  endtask

  initial begin
    logic [5:0]  ops [12];
    logic [31:0] ra;
    logic [31:0] rb;
    int          bc;
    int          guard;
    int          dn;

    n_chk  = 0;
    n_pass = 0;
    m_hi   = 32'd0;
    m_lo   = 32'd0;
    reset  = 1'b0;
    start  = 1'b0;
    dataA  = 32'd0;
    dataB  = 32'd0;
    Signal = 6'd0;
    ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SRL, OP_MFHI, OP_MFLO,
            OP_MULTU, OP_DIVU, 6'b000000, 6'b111111};

    // reset state
    #3;
    chk_val("rst_dataOut", {32'd0, dataOut}, 64'd0);
    chk_val("rst_hi", {32'd0, hi}, 64'd0);
    chk_val("rst_lo", {32'd0, lo}, 64'd0);
    chk_val("rst_busy_done", {62'd0, busy, done}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // basic single-cycle ops
    run_op(OP_ADD, 32'h7FFF_FFFF, 32'd1);
    run_op(OP_SLT, 32'hFFFF_FFFF, 32'd1);
    run_op(OP_SLT, 32'd1, 32'hFFFF_FFFF);
    run_op(OP_SUB, 32'd5, 32'd7);
    run_op(OP_SRL, 32'd31, 32'h8000_0000);
    run_op(OP_SRL, 32'd0, 32'h8000_0001);
    run_op(6'b111110, 32'h1234_5678, 32'h1);

    // back-to-back single-cycle starts
    @(negedge clk);
    Signal = OP_ADD;
    dataA  = 32'd10;
    dataB  = 32'd20;
    start  = 1'b1;
    @(negedge clk);
    chk_val("b2b_done1", {63'd0, done}, 64'd1);
    chk_val("b2b_out1", {32'd0, dataOut}, 64'd30);
    Signal = OP_SUB;
    @(negedge clk);
    chk_val("b2b_done2", {63'd0, done}, 64'd1);
    chk_val("b2b_out2", {32'd0, dataOut}, {32'd0, 32'hFFFF_FFF6});
    start = 1'b0;
    @(negedge clk);
    chk_val("b2b_done_drop", {63'd0, done}, 64'd0);

    // multiply / divide including divide by zero
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(OP_MFHI, 32'd0, 32'd0);
    run_op(OP_MFLO, 32'd0, 32'd0);
    run_op(OP_DIVU, 32'd100, 32'd7);
    run_op(OP_DIVU, 32'd9, 32'd0);

    // async reset in the middle of a divide
    @(negedge clk);
    Signal = OP_DIVU;
    dataA  = 32'd1000;
    dataB  = 32'd3;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk_val("midrst_dataOut", {32'd0, dataOut}, 64'd0);
    chk_val("midrst_hi", {32'd0, hi}, 64'd0);
    chk_val("midrst_lo", {32'd0, lo}, 64'd0);
    chk_val("midrst_busy_done", {62'd0, busy, done}, 64'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    run_op(OP_OR, 32'h0000_00F0, 32'h0000_000F);

    // start while busy is ignored
    @(negedge clk);
    Signal = OP_MULTU;
    dataA  = 32'd3;
    dataB  = 32'd5;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bc    = 0;
    guard = 0;
    dn    = 0;
    while (busy === 1'b1 && guard < 200) begin
      bc++;
      guard++;
      if (done !== 1'b0) dn++;
      if (bc == 10) begin
        start  = 1'b1;
        Signal = OP_ADD;
        dataA  = 32'd1;
        dataB  = 32'd1;
      end else begin
        start = 1'b0;
        dataA = $urandom;
        dataB = $urandom;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk_val("ign_busy_cycles", 64'(bc), 64'd32);
    chk_val("ign_no_early_done", 64'(dn), 64'd0);
    chk_val("ign_done", {63'd0, done}, 64'd1);
    chk_val("ign_lo", {32'd0, lo}, 64'd15);
    chk_val("ign_hi", {32'd0, hi}, 64'd0);
    chk_val("ign_dataOut", {32'd0, dataOut}, 64'd15);
    m_hi = 32'd0;
    m_lo = 32'd15;
    @(negedge clk);
    chk_val("ign_single_done", {63'd0, done}, 64'd0);

    // randomized operations
    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      run_op(ops[$urandom_range(0, 11)], ra, rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_mdu_seq.md
Name: alu_mdu_seq

Overview:
Parametrised sequential ALU. It adds registered outputs, a start/busy/done handshake and an iterative multiply/divide unit with HI/LO registers.
- Single-cycle ops (AND/OR/ADD/SUB/SLT/SRL/MFHI/MFLO) complete in one clock.
- MULTU/DIVU run shift-add / restoring-divide for WIDTH cycles.
- Sits in the EX stage of the multi-cycle datapath; the controller stalls on busy.

Parameters:
WIDTH, 32, operand/result width in bits (≥4, power of two)
SHW, $clog2(WIDTH), shift-amount width (derived, not overridable)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; 0 = reset
start  in  1  launch operation; sampled only when busy=0
dataA  in  WIDTH  operand A
dataB  in  WIDTH  operand B
Signal  in  6  opcode (MIPS funct encoding)
dataOut  out  WIDTH  registered result
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
busy  out  1  multi-cycle op in progress
done  out  1  one-cycle pulse when result valid

Behaviour:
- Reset (reset=0, async): dataOut=0, hi=0, lo=0, busy=0, done=0, state=IDLE, iteration counter=0. Any in-flight MULTU/DIVU is aborted with no partial writes surviving.
- Opcodes:
  - AND 100100
  - OR 100101
  - ADD 100000
  - SUB 100010
  - SLT 101010
  - SRL 000010
  - MFHI 010000
  - MFLO 010010
  - MULTU 011001
  - DIVU 011011
- Arithmetic rules:
  - ADD/SUB: modulo 2^WIDTH; carry/overflow dropped.
  - SLT: signed compare; dataOut = {0…,1} if $signed(dataA) < $signed(dataB), else 0.
  - SRL: logical, dataB >> dataA[SHW-1:0].
  - Unknown opcode: dataOut=0, still completes with done.
- State machine: IDLE, MUL, DIV.
  - IDLE & start & single-cycle op: at that edge dataOut updates; done=1 for the next cycle; busy stays 0. Back-to-back starts give back-to-back done pulses.
  - IDLE & start & MULTU: latch dataA/dataB, clear the product accumulator, enter MUL, busy=1.
    - Each cycle: if multiplier LSB=1 add multiplicand into the upper half, then shift right {carry,acc}.
    - After exactly WIDTH iterations: {hi,lo} = 2·WIDTH-bit product, dataOut=lo, busy=0, done=1 for one cycle, state=IDLE.
  - IDLE & start & DIVU: enter DIV, busy=1, restoring division, one quotient bit per cycle, WIDTH cycles. On finish: lo=quotient, hi=remainder, dataOut=lo, done pulse.
- Latency: single-cycle ops take 1 edge. MULTU/DIVU: busy high for exactly WIDTH cycles; done is asserted in the cycle after the last busy cycle; total WIDTH+1 edges from start to done-visible.
- Divide by zero: no trap. Runs full WIDTH cycles; result lo = all ones, hi = dataA.
- start while busy=1: ignored. Operands and opcode are not sampled; no effect on the running op.
- Operand changes during busy: no effect (latched at start).
- hi/lo change only on MULTU/DIVU completion.
- MFHI/MFLO issued the same edge a mul/div completes cannot happen (busy gates start).
- done is never high while busy=1. done and busy never both 1.
- Counter wraps cleanly to 0 on completion; no stale-state carry into the next op.

Decomposition:
- Package alu_mdu_pkg:
  - opcode localparams (the ten codes above)
  - state enum {IDLE, MUL, DIV}
- Sub-module mdu_iter (iterative multiply/divide datapath):
  - inputs: clk, reset, load, mode, operands
  - outputs: hi/lo, last-iteration flag
- Top holds opcode decode, combinational single-cycle result mux, FSM, output registers.

Test Plan:
1. ADD dataA=32'h7FFFFFFF, dataB=1, start 1 cycle -> next cycle dataOut=32'h80000000, done=1 for one cycle, busy=0.
2. SLT dataA=32'hFFFFFFFF (-1), dataB=1 -> dataOut=1; SUB 5-7 -> dataOut=32'hFFFFFFFE; SRL dataB=32'h80000000, dataA=31 -> dataOut=1.
3. MULTU dataA=32'hFFFFFFFF, dataB=32'hFFFFFFFF -> busy high exactly 32 cycles, then hi=32'hFFFFFFFE, lo=32'h00000001, dataOut=1, single done pulse; MFHI next -> dataOut=32'hFFFFFFFE.
4. DIVU 100/7 -> after 32 busy cycles lo=14, hi=2. DIVU 9/0 -> lo=32'hFFFFFFFF, hi=9, done asserted normally.
5. Start MULTU 3×5; at busy cycle 10 pulse start with ADD 1+1 and change operands -> ignored; final lo=15, hi=0, exactly one done.
6. Start DIVU, assert reset=0 mid-op (async, between edges) -> outputs 0 immediately. Release reset and issue OR 32'hF0,32'h0F -> dataOut=32'hFF, hi=lo=0.
